caravel_clock_ctrl: RTL and testbench
=====================================

// Module: caravel_clock_ctrl
// PURPOSE
//  Clock-source sequencer feeding caravel_clocking's ext_clk_sel, sel and sel2. Runs on
//  the external pad clock and takes PLL/divider requests from housekeeping. Switches to
//  the PLL only after pll_lock has been stable, and changes dividers only while ext_clk is
//  selected. Drops back to ext_clk on lock loss or lock timeout.
// PARAMETERS
//  LOCK_CYCLES     16    consecutive synced-lock cycles required before switching to PLL
//  SETTLE_CYCLES   4     cycles ext_clk stays selected around any divider/source change
//  TIMEOUT_CYCLES  1024  max cycles in WAIT_LOCK before declaring PLL failure
//  CNT_W           11    counter width; must hold TIMEOUT_CYCLES
// PORTS
//  ext_clk      in   1  pad clock; the only clock of this block
//  resetb       in   1  asynchronous active-low reset
//  pll_lock     in   1  PLL lock indicator, asynchronous to ext_clk
//  cfg_valid    in   1  configuration request valid
//  cfg_ready    out  1  request accepted when cfg_valid & cfg_ready
//  cfg_use_pll  in   1  requested source: 1=PLL, 0=ext_clk
//  cfg_sel      in   3  requested core divider value
//  cfg_sel2     in   3  requested user (90-degree) divider value
//  fail_clr     in   1  clears the sticky pll_fail flag
//  ext_clk_sel  out  1  to caravel_clocking: 1=ext clock, 0=PLL clock
//  sel          out  3  to caravel_clocking divider
//  sel2         out  3  to caravel_clocking divider2
//  pll_active   out  1  1 only in RUN_PLL
//  pll_fail     out  1  sticky flag: lock timeout or lock loss
// BEHAVIOUR
//  - Reset values: ext_clk_sel=1, sel=0, sel2=0, cfg_ready=1, pll_active=0, pll_fail=0,
//    state=IDLE_EXT, all counters 0. Synchronizer flops reset to 0.
//  - pll_lock passes through a 2-flop synchronizer (lock_s), which adds 2 cycles of latency.
//    All outputs are registered.
//  - cfg_ready=1 only in IDLE_EXT and RUN_PLL. The request fields are latched on acceptance.
//    cfg_valid while cfg_ready=0 is ignored and not queued.
//  - IDLE_EXT: ext_clk_sel=1. On accept, sel/sel2 load the request in the next cycle.
//    If use_pll=1, go to WAIT_LOCK; otherwise stay in IDLE_EXT.
//  - WAIT_LOCK: ext_clk_sel=1, cfg_ready=0.
//    * lock_cnt increments while lock_s=1 and clears to 0 when lock_s=0.
//    * When lock_cnt reaches LOCK_CYCLES, go to SETTLE.
//    * tmo_cnt increments every cycle. When it reaches TIMEOUT_CYCLES: pll_fail<=1, go to
//      IDLE_EXT. Lock-qualify takes priority over timeout in the same cycle.
//  - SETTLE: ext_clk_sel=1 for SETTLE_CYCLES. If lock_s=0, go back to WAIT_LOCK with both
//    counters cleared. At the end: ext_clk_sel<=0, pll_active<=1, go to RUN_PLL.
//  - RUN_PLL:
//    * If lock_s falls: next cycle ext_clk_sel=1, pll_active=0, pll_fail=1, go to WAIT_LOCK
//      with counters cleared. Lock loss takes priority over a same-cycle cfg accept; that
//      request is not accepted.
//    * On accept: ext_clk_sel<=1, pll_active<=0, go to DRAIN.
//  - DRAIN: ext_clk_sel=1, old sel/sel2 held for SETTLE_CYCLES. Then sel/sel2 load the
//    latched request, and the state goes to WAIT_LOCK if use_pll=1, otherwise to IDLE_EXT.
//    Lock changes are ignored in DRAIN.
//  - Invariant: sel/sel2 never change in a cycle where ext_clk_sel=0, or in the cycle it falls.
//  - pll_fail: set wins over a same-cycle fail_clr. fail_clr alone clears it next cycle.
//  - resetb low in any state returns everything to reset values immediately (async).
// TESTING
//  1 Assert resetb low mid-RUN_PLL -> immediately ext_clk_sel=1, sel=0, sel2=0, pll_fail=0,
//    cfg_ready=1.
//  2 In IDLE_EXT accept {1,3'd2,3'd3}, then raise pll_lock -> sel=2/sel2=3 one cycle after
//    accept; ext_clk_sel=0 exactly 2+16+4=22 cycles after pll_lock rises; pll_active=1.
//  3 Lock low for 1 cycle after 10 high cycles in WAIT_LOCK -> lock_cnt restarts;
//    ext_clk_sel falls 22 cycles after the second rise.
//  4 pll_lock held 0 after accepting use_pll=1 -> pll_fail=1 and state IDLE_EXT 1024 cycles
//    after entering WAIT_LOCK; ext_clk_sel stays 1 throughout.
//  5 pll_lock falls in RUN_PLL -> ext_clk_sel=1 and pll_fail=1 3 cycles later; relock
//    returns to PLL after 22 cycles; fail_clr pulse clears pll_fail.
//  6 In RUN_PLL accept {1,3'd4,3'd5} -> ext_clk_sel=1 next cycle; sel stays 2 for 4 cycles,
//    then becomes 4; the monitor flags any sel change while ext_clk_sel=0.

Source files
------------

// File: rtl/caravel_clock_ctrl_if.sv
`default_nettype none
// ============================================================================
// caravel_clock_ctrl_if : configuration request channel (valid/ready + fields)
// Rev 1.0
// ============================================================================
interface caravel_clock_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_use_pll;
  logic [2:0] cfg_sel;
  logic [2:0] cfg_sel2;

  modport master (
    output cfg_valid,
    output cfg_use_pll,
    output cfg_sel,
    output cfg_sel2,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_use_pll,
    input  cfg_sel,
    input  cfg_sel2,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/caravel_clock_ctrl.sv
`default_nettype none
// ============================================================================
// caravel_clock_ctrl : ext_clk / PLL source sequencer with glitch-safe dividers
// Rev 1.0
// ============================================================================
module caravel_clock_ctrl #(
  parameter int LOCK_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                ext_clk,
  input  logic                resetb,
  input  logic                pll_lock,
  input  logic                fail_clr,
  caravel_clock_ctrl_if.slave cfg,
  output logic                ext_clk_sel,
  output logic [2:0]          sel,
  output logic [2:0]          sel2,
  output logic                pll_active,
  output logic                pll_fail
);

  typedef enum logic [2:0] {
    IDLE_EXT  = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN_PLL   = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_lock_last   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tmo_last    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_sync1;
  logic             r_lock_s;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [CNT_W-1:0] r_set_cnt;
  logic             r_req_use_pll;
  logic [2:0]       r_req_sel;
  logic [2:0]       r_req_sel2;
  logic             w_accept;

  assign w_accept = cfg.cfg_valid & cfg.cfg_ready;

  always_ff @(posedge ext_clk or negedge resetb) begin
    if (!resetb) begin
      r_state       <= IDLE_EXT;
      r_sync1       <= 1'b0;
      r_lock_s      <= 1'b0;
      r_lock_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_set_cnt     <= '0;
      r_req_use_pll <= 1'b0;
      r_req_sel     <= 3'd0;
      r_req_sel2    <= 3'd0;
      ext_clk_sel   <= 1'b1;
      sel           <= 3'd0;
      sel2          <= 3'd0;
      pll_active    <= 1'b0;
      pll_fail      <= 1'b0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
      // Any later set of pll_fail in this cycle overrides the clear.
      if (fail_clr) pll_fail <= 1'b0;

      unique case (r_state)
        IDLE_EXT: begin
          if (w_accept) begin
            sel  <= cfg.cfg_sel;
            sel2 <= cfg.cfg_sel2;
            if (cfg.cfg_use_pll) begin
              r_state       <= WAIT_LOCK;
              cfg.cfg_ready <= 1'b0;
              r_lock_cnt    <= '0;
              r_tmo_cnt     <= '0;
            end
          end
        end

        WAIT_LOCK: begin
          if (r_lock_s && (r_lock_cnt == c_lock_last)) begin
            r_state    <= SETTLE;
            r_lock_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_set_cnt  <= '0;
          end else if (r_tmo_cnt == c_tmo_last) begin
            pll_fail      <= 1'b1;
            r_state       <= IDLE_EXT;
            cfg.cfg_ready <= 1'b1;
            r_lock_cnt    <= '0;
            r_tmo_cnt     <= '0;
          end else begin
            r_lock_cnt <= r_lock_s ? r_lock_cnt + 1'b1 : '0;
            r_tmo_cnt  <= r_tmo_cnt + 1'b1;
          end
        end

        SETTLE: begin
          if (!r_lock_s) begin
            r_state    <= WAIT_LOCK;
            r_lock_cnt <= '0;
            r_tmo_cnt  <= '0;
          end else if (r_set_cnt == c_settle_last) begin
            ext_clk_sel   <= 1'b0;
            pll_active    <= 1'b1;
            cfg.cfg_ready <= 1'b1;
            r_state       <= RUN_PLL;
            r_set_cnt     <= '0;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end

        RUN_PLL: begin
          if (!r_lock_s) begin
            ext_clk_sel   <= 1'b1;
            pll_active    <= 1'b0;
            pll_fail      <= 1'b1;
            cfg.cfg_ready <= 1'b0;
            r_state       <= WAIT_LOCK;
            r_lock_cnt    <= '0;
            r_tmo_cnt     <= '0;
          end else if (w_accept) begin
            r_req_use_pll <= cfg.cfg_use_pll;
            r_req_sel     <= cfg.cfg_sel;
            r_req_sel2    <= cfg.cfg_sel2;
            ext_clk_sel   <= 1'b1;
            pll_active    <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            r_set_cnt     <= '0;
            r_state       <= DRAIN;
          end
        end

        DRAIN: begin
          // Dividers only move after ext_clk has been selected for the full settle window.
          if (r_set_cnt == c_settle_last) begin
            sel        <= r_req_sel;
            sel2       <= r_req_sel2;
            r_set_cnt  <= '0;
            r_lock_cnt <= '0;
            r_tmo_cnt  <= '0;
            if (r_req_use_pll) begin
              r_state <= WAIT_LOCK;
            end else begin
              r_state       <= IDLE_EXT;
              cfg.cfg_ready <= 1'b1;
            end
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end

        default: begin
          r_state       <= IDLE_EXT;
          ext_clk_sel   <= 1'b1;
          pll_active    <= 1'b0;
          cfg.cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_caravel_clock_ctrl.sv
`default_nettype none
// ============================================================================
// tb_caravel_clock_ctrl : scoreboard bench for the clock-source sequencer
// Rev 1.0
// ============================================================================
module tb_caravel_clock_ctrl;

  localparam int LOCK    = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;

  logic       ext_clk;
  logic       resetb;
  logic       pll_lock;
  logic       fail_clr;
  logic       ext_clk_sel;
  logic [2:0] sel;
  logic [2:0] sel2;
  logic       pll_active;
  logic       pll_fail;

  caravel_clock_ctrl_if cfg_if ();

  caravel_clock_ctrl #(
    .LOCK_CYCLES    (LOCK),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (11)
  ) dut (
    .ext_clk     (ext_clk),
    .resetb      (resetb),
    .pll_lock    (pll_lock),
    .fail_clr    (fail_clr),
    .cfg         (cfg_if),
    .ext_clk_sel (ext_clk_sel),
    .sel         (sel),
    .sel2        (sel2),
    .pll_active  (pll_active),
    .pll_fail    (pll_fail)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  typedef struct packed {
    logic       ext;
    logic [2:0] sel;
    logic [2:0] sel2;
    logic       act;
    logic       fail;
    logic       rdy;
  } outv_t;

  typedef struct {
    int    cyc;
    outv_t v;
  } ev_t;

  localparam outv_t C_RST = 10'b1_000_000_0_0_1;
  localparam int P_EXT = 0, P_WAIT = 1, P_SETTLE = 2, P_PLL = 3, P_DRAIN = 4;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  ev_t   q[$];
  outv_t m;
  int    phase;
  int    t_enter;
  int    streak_base;
  bit    hist[$];
  bit    pend_pll;
  bit [2:0] pend_sel, pend_sel2;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: phases tracked by entry timestamps; lock seen two edges late.
  initial begin : model
    outv_t nx;
    bit    ls, acc, set_fail;
    forever begin
      @(posedge ext_clk or negedge resetb);
      if (!resetb) begin
        m = C_RST;
        phase = P_EXT;
        q.delete();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
      end else begin
        cyc++;
        ls = hist[hist.size()-2];
        hist.push_back(pll_lock);
        if (hist.size() > 8) void'(hist.pop_front());
        nx = m;
        acc = m.rdy && cfg_if.cfg_valid;
        set_fail = 1'b0;
        case (phase)
          P_EXT: if (acc) begin
            nx.sel = cfg_if.cfg_sel;
            nx.sel2 = cfg_if.cfg_sel2;
            if (cfg_if.cfg_use_pll) begin
              phase = P_WAIT; t_enter = cyc; streak_base = cyc; nx.rdy = 1'b0;
            end
          end
          P_WAIT: begin
            if (!ls) streak_base = cyc;
            if (ls && (cyc - streak_base == LOCK)) begin
              phase = P_SETTLE; t_enter = cyc;
            end else if (cyc - t_enter == TIMEOUT) begin
              set_fail = 1'b1; phase = P_EXT; nx.rdy = 1'b1;
            end
          end
          P_SETTLE: begin
            if (!ls) begin
              phase = P_WAIT; t_enter = cyc; streak_base = cyc;
            end else if (cyc - t_enter == SETTLE) begin
              phase = P_PLL; nx.ext = 1'b0; nx.act = 1'b1; nx.rdy = 1'b1;
            end
          end
          P_PLL: begin
            if (!ls) begin
              set_fail = 1'b1; nx.ext = 1'b1; nx.act = 1'b0; nx.rdy = 1'b0;
              phase = P_WAIT; t_enter = cyc; streak_base = cyc;
            end else if (acc) begin
              pend_pll = cfg_if.cfg_use_pll; pend_sel = cfg_if.cfg_sel; pend_sel2 = cfg_if.cfg_sel2;
              nx.ext = 1'b1; nx.act = 1'b0; nx.rdy = 1'b0;
              phase = P_DRAIN; t_enter = cyc;
            end
          end
          default: begin
            if (cyc - t_enter == SETTLE) begin
              nx.sel = pend_sel; nx.sel2 = pend_sel2;
              if (pend_pll) begin
                phase = P_WAIT; t_enter = cyc; streak_base = cyc;
              end else begin
                phase = P_EXT; nx.rdy = 1'b1;
              end
            end
          end
        endcase
        nx.fail = set_fail ? 1'b1 : (fail_clr ? 1'b0 : m.fail);
        if (nx != m) q.push_back('{cyc, nx});
        m = nx;
      end
    end
  end

  // Monitor: every DUT output change is matched against the next predicted event.
  initial begin : monitor
    outv_t cur, prev;
    ev_t   e;
    bit    exp_chg;
    prev = C_RST;
    forever begin
      @(negedge ext_clk);
      cur = {ext_clk_sel, sel, sel2, pll_active, pll_fail, cfg_if.cfg_ready};
      if (!resetb) begin
        prev = C_RST;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          n_checks++; n_fail++;
          $display("FAIL stale_event cyc=%0d expected=%h never observed", e.cyc, e.v);
        end
        exp_chg = (q.size() > 0 && q[0].cyc == cyc);
        if (exp_chg || cur != prev) begin
          n_checks++;
          if (!exp_chg) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got=%h was=%h", cyc, cur, prev);
          end else begin
            e = q.pop_front();
            if (cur != e.v) begin
              n_fail++;
              $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, cur, e.v);
            end
          end
        end
        if (cur.sel != prev.sel || cur.sel2 != prev.sel2) begin
          n_checks++;
          if (!cur.ext) begin
            n_fail++;
            $display("FAIL sel_change_on_pll cyc=%0d got ext_clk_sel=0 required 1", cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic send_cfg(input bit up, input bit [2:0] s, input bit [2:0] s2);
    @(negedge ext_clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_use_pll = up;
    cfg_if.cfg_sel = s;
    cfg_if.cfg_sel2 = s2;
    @(posedge ext_clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  // which: 0 ext_clk_sel, 1 sel, 2 pll_fail, 3 cfg_ready
  task automatic wait_until(input int which, input int val, input int lim, output int n);
    int cur;
    n = 0;
    do begin
      @(posedge ext_clk);
      #1;
      n++;
      case (which)
        0:       cur = int'(ext_clk_sel);
        1:       cur = int'(sel);
        2:       cur = int'(pll_fail);
        default: cur = int'(cfg_if.cfg_ready);
      endcase
    end while (cur != val && n < lim);
    if (cur != val) n = -1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, bad;
    resetb = 1'b0;
    pll_lock = 1'b0;
    fail_clr = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_use_pll = 1'b0;
    cfg_if.cfg_sel = 3'd0;
    cfg_if.cfg_sel2 = 3'd0;
    repeat (3) @(negedge ext_clk);
    #2 resetb = 1'b1;

    // Start from ext_clk, request PLL with dividers 2/3.
    send_cfg(1'b1, 3'd2, 3'd3);
    check("t2_sel_after_accept", int'(sel), 2);
    check("t2_sel2_after_accept", int'(sel2), 3);
    @(negedge ext_clk) pll_lock = 1'b1;
    wait_until(0, 0, 40, n);
    check("t2_cycles_to_pll", n, 22);
    check("t2_pll_active", int'(pll_active), 1);

    // Divider change while on PLL.
    send_cfg(1'b1, 3'd4, 3'd5);
    check("t6_ext_after_accept", int'(ext_clk_sel), 1);
    wait_until(1, 4, 10, n);
    check("t6_cycles_to_sel4", n, 4);
    wait_until(0, 0, 40, n);
    check("t6_back_on_pll", int'(n > 0), 1);

    // Lock loss, relock, then clear the sticky flag.
    @(negedge ext_clk) pll_lock = 1'b0;
    wait_until(0, 1, 10, n);
    check("t5_cycles_to_ext", n, 3);
    check("t5_pll_fail_set", int'(pll_fail), 1);
    @(negedge ext_clk) pll_lock = 1'b1;
    wait_until(0, 0, 40, n);
    check("t5_relock_cycles", n, 22);
    @(negedge ext_clk) fail_clr = 1'b1;
    @(negedge ext_clk) fail_clr = 1'b0;
    check("t5_fail_cleared", int'(pll_fail), 0);

    // Back to ext_clk, then a lock streak broken by a one-cycle dropout.
    send_cfg(1'b0, 3'd1, 3'd1);
    @(negedge ext_clk) pll_lock = 1'b0;
    wait_until(3, 1, 10, n);
    check("t3_idle_reached", int'(n > 0), 1);
    send_cfg(1'b1, 3'd2, 3'd3);
    @(negedge ext_clk) pll_lock = 1'b1;
    repeat (10) @(negedge ext_clk);
    pll_lock = 1'b0;
    @(negedge ext_clk) pll_lock = 1'b1;
    wait_until(0, 0, 40, n);
    check("t3_cycles_after_second_rise", n, 22);

    // Lock never arrives: timeout.
    send_cfg(1'b0, 3'd0, 3'd0);
    @(negedge ext_clk) pll_lock = 1'b0;
    wait_until(3, 1, 10, n);
    check("t4_idle_reached", int'(n > 0), 1);
    send_cfg(1'b1, 3'd6, 3'd7);
    n = 0;
    bad = 0;
    do begin
      @(posedge ext_clk);
      #1;
      n++;
      if (!ext_clk_sel) bad++;
    end while (!pll_fail && n < 1100);
    check("t4_cycles_to_timeout", n, 1024);
    check("t4_ext_low_cycles", bad, 0);
    check("t4_ready_after_timeout", int'(cfg_if.cfg_ready), 1);

    // Asynchronous reset in the middle of PLL operation.
    @(negedge ext_clk) pll_lock = 1'b1;
    send_cfg(1'b1, 3'd3, 3'd1);
    wait_until(0, 0, 40, n);
    check("t1_on_pll", int'(n > 0), 1);
    @(posedge ext_clk);
    #3 resetb = 1'b0;
    #1;
    check("t1_ext_clk_sel", int'(ext_clk_sel), 1);
    check("t1_sel", int'(sel), 0);
    check("t1_sel2", int'(sel2), 0);
    check("t1_pll_fail", int'(pll_fail), 0);
    check("t1_pll_active", int'(pll_active), 0);
    check("t1_cfg_ready", int'(cfg_if.cfg_ready), 1);
    repeat (2) @(negedge ext_clk);
    #2 resetb = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge ext_clk);
      if (pll_lock) begin
        if ($urandom_range(0, 79) == 0) pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) pll_lock = 1'b1;
      end
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_use_pll = ($urandom_range(0, 9) < 7);
      cfg_if.cfg_sel = 3'($urandom_range(0, 7));
      cfg_if.cfg_sel2 = 3'($urandom_range(0, 7));
      fail_clr = ($urandom_range(0, 15) == 0);
    end
    @(negedge ext_clk);
    cfg_if.cfg_valid = 1'b0;
    fail_clr = 1'b0;
    repeat (5) @(negedge ext_clk);
    #2;
    check("pending_events_left", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
